dram_responder: RTL and testbench
=================================

# dram_responder

Synthesizable AXI4-Lite-style DRAM responder: the memory-side end of the five-channel read/write interface that our bridge drives. It accepts one read or write at a time, returns data or a write response after a fixed latency, and stores 64-bit words at byte addresses `BASE + 8*index`. It serves as the DRAM model behind the bridge in block-level and system simulation, and as a synthesizable stand-in memory.

## Interface
- `ADDR_W`, 17, width of the byte address.
- `DATA_W`, 64, width of a data word.
- `BASE`, 17'h10000, byte address of word 0.
- `DEPTH`, 256, number of words.
- `LAT`, 2, cycles from the accepting handshake to the response valid. Legal range is LAT ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `AR_VALID`  in  1  read address valid
- `AR_ADDR`  in  ADDR_W  read byte address
- `AR_READY`  out  1  read address accept
- `R_VALID`  out  1  read data valid
- `R_DATA`  out  DATA_W  read data
- `R_RESP`  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
- `R_READY`  in  1  master accepts read data
- `AW_VALID`  in  1  write address valid
- `AW_ADDR`  in  ADDR_W  write byte address
- `AW_READY`  out  1  write address accept
- `W_VALID`  in  1  write data valid
- `W_DATA`  in  DATA_W  write data
- `W_READY`  out  1  write data accept
- `B_VALID`  out  1  write response valid
- `B_RESP`  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- `B_READY`  in  1  master accepts write response

## Operation
- **States:**
  - IDLE
  - R_LAT: latency countdown
  - R_RSP: R_VALID held
  - W_DATA: waiting for W
  - W_LAT: latency countdown
  - B_RSP: B_VALID held
- **Transitions:**
  - IDLE → R_LAT on an AR handshake.
  - IDLE → W_DATA on an AW handshake.
  - R_LAT → R_RSP when the counter expires.
  - R_RSP → IDLE on `R_VALID && R_READY`.
  - W_DATA → W_LAT on a W handshake.
  - W_LAT → B_RSP when the counter expires.
  - B_RSP → IDLE on `B_VALID && B_READY`.
- **Ready signals** are combinational from state and are forced to 0 while `rst` is high:
  - `AR_READY = (state==IDLE)`
  - `AW_READY = (state==IDLE) && !AR_VALID`. Read wins a simultaneous request, and the AW stays pending.
  - `W_READY = (state==W_DATA)`. A W_VALID presented before the AW handshake is not accepted.
- **Address capture:** the address is registered on its handshake.
- **Address is valid when all of the following hold:**
  - `addr >= BASE`
  - `addr < BASE + 8*DEPTH`
  - `addr[2:0] == 0`
- **Word index:** `(addr - BASE) >> 3`, log2(DEPTH) bits.
- **Reads:**
  - Valid address: `R_DATA` = mem[index], sampled at the AR handshake, with `R_RESP = 00`.
  - Invalid address: `R_DATA = 0` and `R_RESP = 10`.
- **Writes:**
  - Valid address: mem[index] ← `W_DATA` on the W handshake edge, and `B_RESP = 00`.
  - Invalid address: memory is unchanged and `B_RESP = 10`.
- **Memory:** DEPTH×DATA_W registers, all cleared to 0 by reset. No byte strobes; whole-word writes only.

## Timing
- **Reset:** while `rst` is high, state = IDLE and the latency counter = 0. All outputs are 0: `AR_READY`, `AW_READY`, `W_READY`, `R_VALID`, `R_DATA`, `R_RESP`, `B_VALID`, `B_RESP`.
- **Reset mid-operation:**
  - Any transaction in flight is dropped and no response is issued.
  - A write whose W handshake had not yet occurred is never committed.
  - A W handshake in the same cycle as `rst` is ignored.
- **First cycle after reset:** `AR_READY = 1` in the first cycle with `rst` low.
- **Read latency:** with the AR handshake in cycle t, `R_VALID` rises in cycle t+LAT.
- **Write latency:** with the W handshake in cycle t, `B_VALID` rises in cycle t+LAT. A LAT=1 response is therefore registered, never combinational from the handshake.
- **Holding a response:** `R_VALID`/`B_VALID` and their data/resp stay constant until the ready handshake. They drop in the cycle after the handshake. Data/resp clear to 0 when valid drops.
- **Back-to-back:** after a response handshake in cycle t, IDLE (ready) is in cycle t+1. There is no pipelining and at most one outstanding transaction.
- **Same-word hazard:** a read issued after a write's B handshake returns the new data.
- **Latency counter:** ceil(log2(LAT+1)) bits, loaded on the accepting handshake, with no wrap.

## Test plan
1. Reset, then AR 0x10000 → AR_READY=1 in the first post-reset cycle. R_VALID arrives at t+2 with R_DATA=0 and R_RESP=00.
2. AW 0x10008, then W_DATA=64'h0123_4567_89AB_CDEF → B_RESP=00 at t+2. A following read of 0x10008 returns 64'h0123_4567_89AB_CDEF.
3. Invalid addresses:
   - Write to 0x10804 (misaligned, out of range) → B_RESP=10, memory unchanged.
   - Read of 0x0FFF8 → R_DATA=0, R_RESP=10.
4. AR_VALID and AW_VALID high in the same cycle → AW_READY=0 and the read completes first. AW_READY then rises after the R handshake, and the write completes.
5. Backpressure: hold R_READY=0 for 5 cycles → R_VALID and R_DATA are held stable. R_VALID drops the cycle after R_READY=1.
6. Reset interruptions:
   - `rst` pulsed during W_DATA after AW 0x10010 → no B_VALID, and mem[2] stays 0.
   - `rst` pulsed during R_RSP → R_VALID is 0 the next cycle.

Source files
------------

// File: rtl/dram_responder.sv
// dram_responder: single-outstanding AXI4-Lite-style memory responder.
// Stores DATA_W-bit words at byte addresses BASE + 8*index and answers after LAT cycles.
module dram_responder #(
    parameter int unsigned       ADDR_W = 17,
    parameter int unsigned       DATA_W = 64,
    parameter logic [ADDR_W-1:0] BASE   = 17'h10000,
    parameter int unsigned       DEPTH  = 256,
    parameter int unsigned       LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AR_VALID,
    input  logic [ADDR_W-1:0] AR_ADDR,
    output logic              AR_READY,
    output logic              R_VALID,
    output logic [DATA_W-1:0] R_DATA,
    output logic [1:0]        R_RESP,
    input  logic              R_READY,
    input  logic              AW_VALID,
    input  logic [ADDR_W-1:0] AW_ADDR,
    output logic              AW_READY,
    input  logic              W_VALID,
    input  logic [DATA_W-1:0] W_DATA,
    output logic              W_READY,
    output logic              B_VALID,
    output logic [1:0]        B_RESP,
    input  logic              B_READY
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LAT + 1);
    localparam logic [ADDR_W:0]  LIMIT    = {1'b0, BASE} + (ADDR_W + 1)'(DEPTH * 8);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_LAT,
        S_R_RSP,
        S_W_DATA,
        S_W_LAT,
        S_B_RSP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_resp;
    logic [1:0]        wr_resp;
    logic [IDX_W-1:0]  aw_idx;
    logic              aw_ok;

    logic              ar_ok;
    logic [IDX_W-1:0]  ar_idx;
    logic              ar_hs;
    logic              aw_hs;
    logic              w_hs;
    logic              r_hs;
    logic              b_hs;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a >= BASE) && ({1'b0, a} < LIMIT) && (a[2:0] == 3'b000);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE;
        return IDX_W'(off >> 3);
    endfunction

    // Everything visible is gated by rst so the reset cycle itself shows all zeros.
    assign AR_READY = !rst && (state == S_IDLE);
    assign AW_READY = !rst && (state == S_IDLE) && !AR_VALID;
    assign W_READY  = !rst && (state == S_W_DATA);
    assign R_VALID  = !rst && (state == S_R_RSP);
    assign B_VALID  = !rst && (state == S_B_RSP);
    assign R_DATA   = R_VALID ? rd_data : '0;
    assign R_RESP   = R_VALID ? rd_resp : '0;
    assign B_RESP   = B_VALID ? wr_resp : '0;

    assign ar_hs = AR_VALID && AR_READY;
    assign aw_hs = AW_VALID && AW_READY;
    assign w_hs  = W_VALID && W_READY;
    assign r_hs  = R_VALID && R_READY;
    assign b_hs  = B_VALID && B_READY;

    assign ar_ok  = addr_ok(AR_ADDR);
    assign ar_idx = addr_idx(AR_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // With LAT==1 the countdown state is skipped so the response lands one cycle after the handshake.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            S_IDLE: begin
                if (ar_hs) begin
                    state_next = (LAT == 1) ? S_R_RSP : S_R_LAT;
                    cnt_next   = LAT_LOAD;
                end else if (aw_hs) begin
                    state_next = S_W_DATA;
                end
            end
            S_R_LAT: begin
                if (cnt <= CNT_W'(1)) begin
                    state_next = S_R_RSP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_R_RSP: begin
                if (r_hs) state_next = S_IDLE;
            end
            S_W_DATA: begin
                if (w_hs) begin
                    state_next = (LAT == 1) ? S_B_RSP : S_W_LAT;
                    cnt_next   = LAT_LOAD;
                end
            end
            S_W_LAT: begin
                if (cnt <= CNT_W'(1)) begin
                    state_next = S_B_RSP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_B_RSP: begin
                if (b_hs) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_resp <= '0;
            wr_resp <= '0;
            aw_idx  <= '0;
            aw_ok   <= 1'b0;
        end else begin
            if (ar_hs) begin
                rd_data <= ar_ok ? mem[ar_idx] : '0;
                rd_resp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_hs) begin
                rd_data <= '0;
                rd_resp <= '0;
            end
            if (aw_hs) begin
                aw_idx <= addr_idx(AW_ADDR);
                aw_ok  <= addr_ok(AW_ADDR);
            end
            if (w_hs) begin
                wr_resp <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (b_hs) begin
                wr_resp <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else if (w_hs && aw_ok) begin
            mem[aw_idx] <= W_DATA;
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: vector table plus hand sequences, responses checked through a scoreboard queue.
module tb_dram_responder;

    localparam int LAT     = 2;
    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        AR_VALID;
    logic [16:0] AR_ADDR;
    logic        AR_READY;
    logic        R_VALID;
    logic [63:0] R_DATA;
    logic [1:0]  R_RESP;
    logic        R_READY;
    logic        AW_VALID;
    logic [16:0] AW_ADDR;
    logic        AW_READY;
    logic        W_VALID;
    logic [63:0] W_DATA;
    logic        W_READY;
    logic        B_VALID;
    logic [1:0]  B_RESP;
    logic        B_READY;

    always #5 clk = ~clk;

    dram_responder #(
        .ADDR_W(17),
        .DATA_W(64),
        .BASE  (17'h10000),
        .DEPTH (256),
        .LAT   (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .AR_VALID(AR_VALID),
        .AR_ADDR (AR_ADDR),
        .AR_READY(AR_READY),
        .R_VALID (R_VALID),
        .R_DATA  (R_DATA),
        .R_RESP  (R_RESP),
        .R_READY (R_READY),
        .AW_VALID(AW_VALID),
        .AW_ADDR (AW_ADDR),
        .AW_READY(AW_READY),
        .W_VALID (W_VALID),
        .W_DATA  (W_DATA),
        .W_READY (W_READY),
        .B_VALID (B_VALID),
        .B_RESP  (B_RESP),
        .B_READY (B_READY)
    );

    typedef struct {
        logic        is_wr;
        logic [63:0] data;
        logic [1:0]  resp;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [16:0] addr;
        logic [63:0] data;
        logic [1:0]  resp;
        int          gap;
        int          hold;
    } vec_t;

    rsp_t sb[$];
    vec_t vecs[15];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: no event within %0d cycles", name, TIMEOUT);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string name, input logic is_wr, input logic [63:0] data,
                             input logic [1:0] resp);
        rsp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: response with empty scoreboard", name);
            return;
        end
        e = sb.pop_front();
        check({name, "_kind"}, is_wr, e.is_wr);
        check({name, "_data"}, data, e.data);
        check({name, "_resp"}, resp, e.resp);
    endtask

    task automatic do_read(input logic [16:0] addr, input logic [63:0] exp_data,
                           input logic [1:0] exp_resp, input int hold);
        int n;
        AR_VALID = 1'b1;
        AR_ADDR  = addr;
        #1;
        n = 0;
        while (!AR_READY && n < TIMEOUT) begin
            step();
            n++;
        end
        if (!AR_READY) begin
            timeout("ar_ready");
            AR_VALID = 1'b0;
            return;
        end
        sb.push_back('{1'b0, exp_data, exp_resp});
        step();
        AR_VALID = 1'b0;
        #1;
        n = 1;
        while (!R_VALID && n < TIMEOUT) begin
            step();
            n++;
        end
        if (!R_VALID) begin
            timeout("r_valid");
            void'(sb.pop_front());
            return;
        end
        check("r_latency", n, LAT);
        for (int i = 0; i < hold; i++) begin
            check("r_hold_valid", R_VALID, 1);
            check("r_hold_data", R_DATA, sb[0].data);
            check("r_hold_resp", R_RESP, sb[0].resp);
            step();
        end
        R_READY = 1'b1;
        pop_check("r", 1'b0, R_DATA, R_RESP);
        step();
        R_READY = 1'b0;
        #1;
        check("r_drop", R_VALID, 0);
        check("r_data_clear", R_DATA, 0);
        check("ar_ready_after_r", AR_READY, 1);
    endtask

    task automatic do_write(input logic [16:0] addr, input logic [63:0] wdata,
                            input logic [1:0] exp_resp, input int gap, input int hold);
        int n;
        AW_VALID = 1'b1;
        AW_ADDR  = addr;
        #1;
        n = 0;
        while (!AW_READY && n < TIMEOUT) begin
            step();
            n++;
        end
        if (!AW_READY) begin
            timeout("aw_ready");
            AW_VALID = 1'b0;
            return;
        end
        step();
        AW_VALID = 1'b0;
        for (int i = 0; i < gap; i++) begin
            check("w_ready_wait", W_READY, 1);
            check("b_quiet", B_VALID, 0);
            step();
        end
        W_VALID = 1'b1;
        W_DATA  = wdata;
        #1;
        check("w_ready", W_READY, 1);
        sb.push_back('{1'b1, 64'h0, exp_resp});
        step();
        W_VALID = 1'b0;
        #1;
        n = 1;
        while (!B_VALID && n < TIMEOUT) begin
            step();
            n++;
        end
        if (!B_VALID) begin
            timeout("b_valid");
            void'(sb.pop_front());
            return;
        end
        check("b_latency", n, LAT);
        for (int i = 0; i < hold; i++) begin
            check("b_hold_valid", B_VALID, 1);
            check("b_hold_resp", B_RESP, sb[0].resp);
            step();
        end
        B_READY = 1'b1;
        pop_check("b", 1'b1, 64'h0, B_RESP);
        step();
        B_READY = 1'b0;
        #1;
        check("b_drop", B_VALID, 0);
        check("b_resp_clear", B_RESP, 0);
        check("aw_ready_after_b", AW_READY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        vecs[0]  = '{1'b1, 17'h10008, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0};
        vecs[1]  = '{1'b0, 17'h10008, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0};
        vecs[2]  = '{1'b1, 17'h10804, 64'hDEAD_BEEF_DEAD_BEEF, 2'b10, 1, 2};
        vecs[3]  = '{1'b0, 17'h0FFF8, 64'h0,                   2'b10, 0, 0};
        vecs[4]  = '{1'b0, 17'h10000, 64'h0,                   2'b00, 0, 0};
        vecs[5]  = '{1'b1, 17'h10000, 64'h1111_2222_3333_4444, 2'b00, 0, 3};
        vecs[6]  = '{1'b1, 17'h107F8, 64'hAAAA_5555_AAAA_5555, 2'b00, 2, 0};
        vecs[7]  = '{1'b0, 17'h107F8, 64'hAAAA_5555_AAAA_5555, 2'b00, 0, 5};
        vecs[8]  = '{1'b0, 17'h10800, 64'h0,                   2'b10, 0, 0};
        vecs[9]  = '{1'b0, 17'h10001, 64'h0,                   2'b10, 0, 0};
        vecs[10] = '{1'b1, 17'h10004, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 0, 0};
        vecs[11] = '{1'b0, 17'h10000, 64'h1111_2222_3333_4444, 2'b00, 0, 1};
        vecs[12] = '{1'b0, 17'h107F0, 64'h0,                   2'b00, 0, 0};
        vecs[13] = '{1'b1, 17'h0FFF8, 64'h0BAD_0BAD_0BAD_0BAD, 2'b10, 0, 0};
        vecs[14] = '{1'b0, 17'h107F8, 64'hAAAA_5555_AAAA_5555, 2'b00, 0, 0};

        rst      = 1'b1;
        AR_VALID = 1'b1;
        AR_ADDR  = 17'h10000;
        R_READY  = 1'b0;
        AW_VALID = 1'b1;
        AW_ADDR  = 17'h10008;
        W_VALID  = 1'b1;
        W_DATA   = 64'h5;
        B_READY  = 1'b0;
        repeat (3) step();

        check("rst_ar_ready", AR_READY, 0);
        check("rst_aw_ready", AW_READY, 0);
        check("rst_w_ready",  W_READY, 0);
        check("rst_r_valid",  R_VALID, 0);
        check("rst_r_data",   R_DATA, 0);
        check("rst_r_resp",   R_RESP, 0);
        check("rst_b_valid",  B_VALID, 0);
        check("rst_b_resp",   B_RESP, 0);

        AR_VALID = 1'b0;
        AW_VALID = 1'b0;
        W_VALID  = 1'b0;
        rst      = 1'b0;
        #1;
        check("first_cycle_ar_ready", AR_READY, 1);
        do_read(17'h10000, 64'h0, 2'b00, 0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].gap, vecs[i].hold);
            else
                do_read(vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].hold);
        end

        // Simultaneous AR and AW: read goes first, AW waits for the R handshake.
        AR_VALID = 1'b1;
        AR_ADDR  = 17'h10008;
        AW_VALID = 1'b1;
        AW_ADDR  = 17'h10018;
        #1;
        check("sim_ar_ready", AR_READY, 1);
        check("sim_aw_ready", AW_READY, 0);
        sb.push_back('{1'b0, 64'h0123_4567_89AB_CDEF, 2'b00});
        step();
        AR_VALID = 1'b0;
        #1;
        n = 1;
        while (!R_VALID && n < TIMEOUT) begin
            check("sim_aw_blocked", AW_READY, 0);
            step();
            n++;
        end
        if (!R_VALID) begin
            timeout("sim_r_valid");
            void'(sb.pop_front());
        end else begin
            check("sim_aw_blocked_rsp", AW_READY, 0);
            R_READY = 1'b1;
            pop_check("sim_r", 1'b0, R_DATA, R_RESP);
            step();
            R_READY = 1'b0;
            #1;
            check("sim_aw_ready_after_r", AW_READY, 1);
        end
        do_write(17'h10018, 64'h5A5A_A5A5_5A5A_A5A5, 2'b00, 0, 0);
        do_read(17'h10018, 64'h5A5A_A5A5_5A5A_A5A5, 2'b00, 0);

        // Reset while waiting for W: write is dropped, no B response.
        AW_VALID = 1'b1;
        AW_ADDR  = 17'h10010;
        #1;
        check("rw_aw_ready", AW_READY, 1);
        step();
        AW_VALID = 1'b0;
        #1;
        check("rw_w_ready", W_READY, 1);
        rst     = 1'b1;
        W_VALID = 1'b1;
        W_DATA  = 64'h7777_8888_9999_AAAA;
        #1;
        check("rw_w_ready_in_rst", W_READY, 0);
        step();
        rst     = 1'b0;
        W_VALID = 1'b0;
        #1;
        check("rw_idle_after_rst", AR_READY, 1);
        check("rw_w_ready_after_rst", W_READY, 0);
        for (int i = 0; i < LAT + 3; i++) begin
            check("rw_no_b", B_VALID, 0);
            step();
        end
        do_read(17'h10010, 64'h0, 2'b00, 0);
        do_read(17'h10008, 64'h0, 2'b00, 0);

        // Reset while R_VALID is held: response is dropped.
        do_write(17'h10020, 64'hCAFE_F00D_CAFE_F00D, 2'b00, 0, 0);
        AR_VALID = 1'b1;
        AR_ADDR  = 17'h10020;
        #1;
        check("rr_ar_ready", AR_READY, 1);
        step();
        AR_VALID = 1'b0;
        #1;
        n = 1;
        while (!R_VALID && n < TIMEOUT) begin
            step();
            n++;
        end
        if (!R_VALID) begin
            timeout("rr_r_valid");
        end else begin
            check("rr_r_data", R_DATA, 64'hCAFE_F00D_CAFE_F00D);
            rst = 1'b1;
            #1;
            check("rr_r_valid_in_rst", R_VALID, 0);
            step();
            rst = 1'b0;
            #1;
            check("rr_r_valid_after", R_VALID, 0);
            check("rr_r_data_after", R_DATA, 0);
            check("rr_ar_ready_after", AR_READY, 1);
            for (int i = 0; i < LAT + 2; i++) begin
                check("rr_no_r", R_VALID, 0);
                step();
            end
        end
        do_read(17'h10020, 64'h0, 2'b00, 0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
